syn_vga_rx: RTL and testbench
=============================

// Module: syn_vga_rx
// PURPOSE
//  Receive end of the DE1 VGA link: samples r/g/b/hsync_n/vsync_n as driven by the VGA
//  output path and recovers frame timing. Emits an active-pixel stream with (x,y) coordinates.
//  Checks sync widths, line length and frame height against the programmed timing.
//  Used as a synthesizable loopback monitor and as the checker behind the TB modport.
// PARAMETERS
//  WIDTH     4    bits per colour channel
//  H_SYNC    96   hsync low width, samples
//  H_BP      48   horizontal back porch, samples
//  H_ACTIVE  640  active pixels per line
//  H_FP      16   horizontal front porch; H_TOTAL = sum of the four = 800
//  V_SYNC    2    vsync low width, lines
//  V_BP      33   vertical back porch, lines
//  V_ACTIVE  480  active lines
//  V_FP      10   vertical front porch; V_TOTAL = 525
// PORTS
//  clk_ir         in   1        system clock; the only clock
//  rst_il         in   1        synchronous, active-high reset
//  pix_en_i       in   1        pixel strobe: inputs are sampled only on cycles where this is 1
//  vga_r_i        in   WIDTH    red
//  vga_g_i        in   WIDTH    green
//  vga_b_i        in   WIDTH    blue
//  vga_hsync_n_i  in   1        horizontal sync, active low
//  vga_vsync_n_i  in   1        vertical sync, active low
//  err_clr_i      in   1        clears the sticky error flags
//  pxl_valid_o    out  1        active pixel on pxl_* this cycle
//  pxl_x_o        out  10       column 0..H_ACTIVE-1
//  pxl_y_o        out  9        row 0..V_ACTIVE-1
//  pxl_rgb_o      out  3*WIDTH  {r,g,b}
//  frame_done_o   out  1        1-cycle pulse after the last active line
//  frame_cnt_o    out  16       completed frames; wraps 0xFFFF->0
//  locked_o       out  1        timing validated
//  err_hsync_o    out  1        sticky: bad hsync width
//  err_hline_o    out  1        sticky: bad line length
//  err_vframe_o   out  1        sticky: bad frame height or misplaced vsync
// BEHAVIOUR
//  - Reset: every output is 0; FSM goes to IDLE; all counters are 0.
//    Reset mid-frame aborts the frame; no pxl_valid_o until the next full VSYNC->VBP pass.
//  - Input register stage, loaded on pix_en_i. The previous sample is kept for edge detection.
//    Non-strobe cycles hold all state.
//  - hcnt: set to 0 on the hsync_n 1->0 sample, else +1 per sample; saturates at 1023.
//    * hsync 0->1 sample with hcnt!=H_SYNC sets err_hsync.
//    * hsync fall while locked_o=1 with previous hcnt!=H_TOTAL-1 sets err_hline.
//  - vcnt: +1 on each hsync fall; set to 0 on the vsync_n 1->0 sample; saturates at 1023.
//  - FSM states:
//    * IDLE: wait for vsync fall -> VSYNC.
//    * VSYNC: on vsync rise -> VBP; err_vframe if vcnt!=V_SYNC.
//    * VBP: vcnt==V_SYNC+V_BP -> VACT.
//    * VACT: after V_ACTIVE lines -> VFP; pulses frame_done_o and increments frame_cnt_o.
//    * VFP: on vsync fall -> VSYNC; err_vframe if previous vcnt!=V_TOTAL-1.
//    * vsync fall in VBP or VACT sets err_vframe and goes -> VSYNC.
//  - Active pixel: state VACT and hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1].
//    x = hcnt-(H_SYNC+H_BP); y = vcnt-(V_SYNC+V_BP).
//    Output is registered; latency is 2 clk from the strobe cycle carrying the pixel.
//  - locked_o: set at the VFP->VSYNC transition of an error-free frame.
//    Cleared in the same cycle any error flag sets.
//  - Sticky errors: set the cycle after detection. A set on the same cycle as err_clr_i wins.
// CONFIGURATION
//  SYN_VGA_RX_CRC_EN defined:
//   - adds output port frame_crc_o[15:0]: CRC-16-CCITT (init 0xFFFF) over pxl_rgb_o, MSB first.
//   - value latched with frame_done_o; accumulator reset at VBP->VACT.
//  Not defined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  syn_vga_pkg: default timing localparams, H_TOTAL/V_TOTAL, the FSM enum
//   syn_vga_rx_st_t {IDLE,VSYNC,VBP,VACT,VFP}, and the CRC polynomial constant.
//  Sub-module syn_vga_rx_crc16 (clk, rst, en, data[3*WIDTH], crc), only under the macro.
// TESTING
//  1. Two 640x480 frames, pix_en every 2nd clk, rgb={x[3:0],y[3:0],4'h5}
//     -> 307200 pxl_valid per frame; first (0,0) rgb=0x005; last (639,479) rgb=0xFF5;
//        frame_done x2; frame_cnt=2; locked=1 after frame 1; no errors.
//  2. One line with a 95-sample hsync -> err_hsync=1 and locked=0.
//     Then err_clr_i pulse -> err_hsync=0.
//  3. One line of 801 samples while locked -> err_hline=1 at the next hsync fall.
//     Pixels still produced.
//  4. Frame of 524 lines -> err_vframe=1 at the vsync fall; frame_done still pulsed once.
//  5. rst_il high for 1 clk at y=100 -> outputs 0 next clk; no pxl_valid until after
//     the next VSYNC+VBP; y restarts at 0.
//  6. With SYN_VGA_RX_CRC_EN, a constant 0xFFF frame -> frame_crc_o equals the TB model
//     CRC on frame_done; a second identical frame gives the same value.

Source files
------------

// File: rtl/syn_vga_pkg.sv
// Shared timing defaults, FSM state type and CRC constants for the VGA receive monitor.
package syn_vga_pkg;

  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;

  localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACTIVE + DEF_V_FP;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    VACT,
    VFP
  } syn_vga_rx_st_t;

endpackage

// File: rtl/syn_vga_rx_crc16.sv
// CRC-16-CCITT accumulator over one {r,g,b} word per enabled cycle, MSB first.
module syn_vga_rx_crc16
  import syn_vga_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [3*WIDTH-1:0]   data,
  output logic [15:0]          crc
);

  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [3*WIDTH-1:0] d);
    logic [15:0] n;
    n = c;
    for (int i = 3 * WIDTH - 1; i >= 0; i--) begin
      if (n[15] ^ d[i]) n = {n[14:0], 1'b0} ^ CRC16_POLY;
      else              n = {n[14:0], 1'b0};
    end
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)     crc <= CRC16_INIT;
    else if (en) crc <= crc_next(crc, data);
  end

endmodule

// File: rtl/syn_vga_rx.sv
// VGA link receiver: recovers frame timing, emits active pixels with coordinates, flags timing
// errors. Define SYN_VGA_RX_CRC_EN to add a per-frame CRC-16 output (frame_crc_o).
module syn_vga_rx
  import syn_vga_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP
) (
  input  logic               clk_ir,
  input  logic               rst_il,
  input  logic               pix_en_i,
  input  logic [WIDTH-1:0]   vga_r_i,
  input  logic [WIDTH-1:0]   vga_g_i,
  input  logic [WIDTH-1:0]   vga_b_i,
  input  logic               vga_hsync_n_i,
  input  logic               vga_vsync_n_i,
  input  logic               err_clr_i,
`ifdef SYN_VGA_RX_CRC_EN
  output logic [15:0]        frame_crc_o,
`endif
  output logic               pxl_valid_o,
  output logic [9:0]         pxl_x_o,
  output logic [8:0]         pxl_y_o,
  output logic [3*WIDTH-1:0] pxl_rgb_o,
  output logic               frame_done_o,
  output logic [15:0]        frame_cnt_o,
  output logic               locked_o,
  output logic               err_hsync_o,
  output logic               err_hline_o,
  output logic               err_vframe_o
);

  localparam logic [9:0] CNT_MAX     = 10'h3FF;
  localparam logic [9:0] H_SYNC_CNT  = 10'(H_SYNC);
  localparam logic [9:0] H_LAST      = 10'(H_SYNC + H_BP + H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_ACT_FIRST = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_ACT_LAST  = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_SYNC_CNT  = 10'(V_SYNC);
  localparam logic [9:0] V_ACT_FIRST = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] V_LAST      = 10'(V_SYNC + V_BP + V_ACTIVE + V_FP - 1);

  // Sample stage; en_q marks the cycle in which a freshly strobed sample is processed.
  logic               en_q;
  logic [WIDTH-1:0]   r_q, g_q, b_q;
  logic               hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic               hs_seen_q;
  logic [9:0]         hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  syn_vga_rx_st_t     state_q, state_d;
  logic               frame_ok_q;

  logic hfall, hrise, vfall, vrise;
  logic det_hsync, det_hline, det_vframe, any_det;
  logic act_start, frame_end, relock, enter_vsync;
  logic pix_valid;
  logic [3*WIDTH-1:0] pix_rgb;

  assign pix_rgb = {r_q, g_q, b_q};

  always_comb begin
    hfall = en_q & hs_prev_q & ~hs_q;
    hrise = en_q & ~hs_prev_q & hs_q;
    vfall = en_q & vs_prev_q & ~vs_q;
    vrise = en_q & ~vs_prev_q & vs_q;

    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (en_q) begin
      if (hfall)                 hcnt_d = '0;
      else if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 10'd1;
      if (vfall)                         vcnt_d = '0;
      else if (hfall && vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
    end

    // Width is only meaningful once a falling edge has been seen since reset.
    det_hsync = hrise & hs_seen_q & (hcnt_d != H_SYNC_CNT);
    det_hline = hfall & locked_o & (hcnt_q != H_LAST);
  end

  always_comb begin
    state_d    = state_q;
    det_vframe = 1'b0;
    act_start  = 1'b0;
    frame_end  = 1'b0;
    relock     = 1'b0;
    if (en_q) begin
      unique case (state_q)
        IDLE: if (vfall) state_d = VSYNC;
        VSYNC: begin
          if (vrise) begin
            state_d    = VBP;
            det_vframe = (vcnt_d != V_SYNC_CNT);
          end
        end
        VBP: begin
          if (vfall) begin
            state_d    = VSYNC;
            det_vframe = 1'b1;
          end else if (vcnt_d == V_ACT_FIRST) begin
            state_d   = VACT;
            act_start = 1'b1;
          end
        end
        VACT: begin
          if (vfall) begin
            state_d    = VSYNC;
            det_vframe = 1'b1;
          end else if (vcnt_d == V_ACT_END) begin
            state_d   = VFP;
            frame_end = 1'b1;
          end
        end
        VFP: begin
          if (vfall) begin
            state_d    = VSYNC;
            det_vframe = (vcnt_q != V_LAST);
            relock     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    enter_vsync = (state_d == VSYNC) && (state_q != VSYNC);
    any_det     = det_hsync | det_hline | det_vframe;
    pix_valid   = en_q && (state_q == VACT) && (hcnt_d >= H_ACT_FIRST) && (hcnt_d <= H_ACT_LAST);
  end

  always_ff @(posedge clk_ir) begin
    if (rst_il) begin
      en_q         <= 1'b0;
      r_q          <= '0;
      g_q          <= '0;
      b_q          <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      hs_seen_q    <= 1'b0;
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      state_q      <= IDLE;
      frame_ok_q   <= 1'b0;
      pxl_valid_o  <= 1'b0;
      pxl_x_o      <= '0;
      pxl_y_o      <= '0;
      pxl_rgb_o    <= '0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
      locked_o     <= 1'b0;
      err_hsync_o  <= 1'b0;
      err_hline_o  <= 1'b0;
      err_vframe_o <= 1'b0;
    end else begin
      en_q <= pix_en_i;
      if (pix_en_i) begin
        r_q       <= vga_r_i;
        g_q       <= vga_g_i;
        b_q       <= vga_b_i;
        hs_prev_q <= hs_q;
        vs_prev_q <= vs_q;
        hs_q      <= vga_hsync_n_i;
        vs_q      <= vga_vsync_n_i;
      end
      if (hfall) hs_seen_q <= 1'b1;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      state_q <= state_d;

      pxl_valid_o <= pix_valid;
      if (pix_valid) begin
        pxl_x_o   <= hcnt_d - H_ACT_FIRST;
        pxl_y_o   <= 9'(vcnt_d - V_ACT_FIRST);
        pxl_rgb_o <= pix_rgb;
      end

      frame_done_o <= frame_end;
      if (frame_end) frame_cnt_o <= frame_cnt_o + 16'd1;

      // A new frame starts clean; errors of the closing frame still block relock below.
      if (enter_vsync)  frame_ok_q <= 1'b1;
      else if (any_det) frame_ok_q <= 1'b0;

      if (any_det)                  locked_o <= 1'b0;
      else if (relock && frame_ok_q) locked_o <= 1'b1;

      err_hsync_o  <= (err_hsync_o & ~err_clr_i) | det_hsync;
      err_hline_o  <= (err_hline_o & ~err_clr_i) | det_hline;
      err_vframe_o <= (err_vframe_o & ~err_clr_i) | det_vframe;
    end
  end

`ifdef SYN_VGA_RX_CRC_EN
  logic [15:0] crc;

  syn_vga_rx_crc16 #(
    .WIDTH (WIDTH)
  ) u_crc (
    .clk  (clk_ir),
    .rst  (rst_il | act_start),
    .en   (pix_valid),
    .data (pix_rgb),
    .crc  (crc)
  );

  always_ff @(posedge clk_ir) begin
    if (rst_il)         frame_crc_o <= '0;
    else if (frame_end) frame_crc_o <= crc;
  end
`endif

endmodule

// File: tb/tb_syn_vga_rx.sv
// Bench for syn_vga_rx with a reduced raster; pixels are checked through a scoreboard queue.
module tb_syn_vga_rx;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned H_SYNC   = 4;
  localparam int unsigned H_BP     = 3;
  localparam int unsigned H_ACTIVE = 12;
  localparam int unsigned H_FP     = 2;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 3;
  localparam int unsigned V_ACTIVE = 6;
  localparam int unsigned V_FP     = 2;
  localparam int unsigned H_TOTAL  = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL  = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_FIRST  = H_SYNC + H_BP;
  localparam int unsigned V_FIRST  = V_SYNC + V_BP;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] rgb;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_en = 1'b0;
  logic [3:0]  r = '0, g = '0, b = '0;
  logic        hs = 1'b1, vs = 1'b1;
  logic        err_clr = 1'b0;
  logic        pxl_valid, frame_done, locked, err_hsync, err_hline, err_vframe;
  logic [9:0]  pxl_x;
  logic [8:0]  pxl_y;
  logic [11:0] pxl_rgb;
  logic [15:0] frame_cnt;
`ifdef SYN_VGA_RX_CRC_EN
  logic [15:0] frame_crc;
`endif

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned done_cnt = 0;
  bit          const_rgb = 1'b0;
  pix_t        sb[$];

  syn_vga_rx #(
    .WIDTH    (WIDTH),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP)
  ) dut (
    .clk_ir        (clk),
    .rst_il        (rst),
    .pix_en_i      (pix_en),
    .vga_r_i       (r),
    .vga_g_i       (g),
    .vga_b_i       (b),
    .vga_hsync_n_i (hs),
    .vga_vsync_n_i (vs),
    .err_clr_i     (err_clr),
`ifdef SYN_VGA_RX_CRC_EN
    .frame_crc_o   (frame_crc),
`endif
    .pxl_valid_o   (pxl_valid),
    .pxl_x_o       (pxl_x),
    .pxl_y_o       (pxl_y),
    .pxl_rgb_o     (pxl_rgb),
    .frame_done_o  (frame_done),
    .frame_cnt_o   (frame_cnt),
    .locked_o      (locked),
    .err_hsync_o   (err_hsync),
    .err_hline_o   (err_hline),
    .err_vframe_o  (err_vframe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Output monitor: every emitted pixel must match the oldest expected one.
  always @(negedge clk) begin
    pix_t e;
    if (frame_done) done_cnt++;
    if (pxl_valid) begin
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pxl_x", 32'(pxl_x), 32'(e.x));
        check("pxl_y", 32'(pxl_y), 32'(e.y));
        check("pxl_rgb", 32'(pxl_rgb), 32'(e.rgb));
      end
    end
  end

  // One strobed sample followed by one idle clock.
  task automatic send_sample(input logic h, input logic v, input logic [11:0] rgb);
    @(negedge clk);
    hs = h;
    vs = v;
    {r, g, b} = rgb;
    pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
  endtask

  task automatic send_line(input int line, input int total, input int hs_len, input bit push,
                           input int stop);
    logic [11:0] rgb;
    pix_t        p;
    int          x, y;
    bit          act;
    for (int h = 0; h < total && h < stop; h++) begin
      x   = h - int'(H_FIRST);
      y   = line - int'(V_FIRST);
      act = (line >= int'(V_FIRST)) && (line < int'(V_FIRST + V_ACTIVE)) &&
            (h >= int'(H_FIRST)) && (h < int'(H_FIRST + H_ACTIVE));
      rgb = '0;
      if (act) begin
        rgb = const_rgb ? 12'hFFF : {x[3:0], y[3:0], 4'h5};
        if (push) begin
          p.x   = 10'(x);
          p.y   = 9'(y);
          p.rgb = rgb;
          sb.push_back(p);
        end
      end
      send_sample(h >= hs_len, line >= int'(V_SYNC), rgb);
    end
  endtask

  task automatic send_frame(input int n_lines);
    for (int l = 0; l < n_lines; l++) send_line(l, H_TOTAL, H_SYNC, 1'b1, H_TOTAL);
  endtask

`ifdef SYN_VGA_RX_CRC_EN
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] s;
    logic        fb;
    s = c;
    for (int i = 11; i >= 0; i--) begin
      fb = s[15] ^ d[i];
      s  = s << 1;
      if (fb) s = s ^ 16'h1021;
    end
    return s;
  endfunction
`endif

  initial begin
    int unsigned done_base;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(pxl_valid), 32'd0);
    check("rst_xy_rgb", {pxl_x, pxl_y, pxl_rgb}, 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_errors", 32'({err_hsync, err_hline, err_vframe}), 32'd0);

    // Two clean frames; lock appears once the first frame has closed.
    send_frame(V_TOTAL);
    check("f1_locked", 32'(locked), 32'd0);
    check("f1_done", done_cnt, 32'd1);
    send_frame(V_TOTAL);
    check("f2_locked", 32'(locked), 32'd1);
    check("f2_frame_cnt", 32'(frame_cnt), 32'd2);
    check("f2_done", done_cnt, 32'd2);
    check("f2_errors", 32'({err_hsync, err_hline, err_vframe}), 32'd0);
    check("f2_sb_empty", sb.size(), 32'd0);

    // Frame 3: one line one sample too long while locked.
    for (int l = 0; l < int'(V_TOTAL); l++) begin
      if (l == int'(V_FIRST) + 1) begin
        send_line(l, H_TOTAL + 1, H_SYNC, 1'b1, H_TOTAL + 1);
        check("hline_before_fall", 32'(err_hline), 32'd0);
      end else begin
        send_line(l, H_TOTAL, H_SYNC, 1'b1, H_TOTAL);
      end
      if (l == int'(V_FIRST) + 2) begin
        check("hline_set", 32'(err_hline), 32'd1);
        check("hline_unlock", 32'(locked), 32'd0);
      end
    end

    // Frame 4 clean; frame 5 relocks, then carries a short hsync pulse.
    send_frame(V_TOTAL);
    for (int l = 0; l < int'(V_TOTAL); l++) begin
      if (l == int'(V_FIRST) + 2) send_line(l, H_TOTAL, H_SYNC - 1, 1'b1, H_TOTAL);
      else                        send_line(l, H_TOTAL, H_SYNC, 1'b1, H_TOTAL);
      if (l == 0) check("relocked", 32'(locked), 32'd1);
      if (l == int'(V_FIRST) + 2) begin
        check("hsync_set", 32'(err_hsync), 32'd1);
        check("hsync_unlock", 32'(locked), 32'd0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("hsync_cleared", 32'(err_hsync), 32'd0);
        check("hline_cleared", 32'(err_hline), 32'd0);
      end
    end
    check("f5_frame_cnt", 32'(frame_cnt), 32'd5);

    // Frame 6 one line short; flagged at the next vsync fall.
    done_base = done_cnt;
    send_frame(V_TOTAL - 1);
    check("short_done_once", done_cnt - done_base, 32'd1);
    check("short_no_err_yet", 32'(err_vframe), 32'd0);
    send_line(0, H_TOTAL, H_SYNC, 1'b1, H_TOTAL);
    check("vframe_set", 32'(err_vframe), 32'd1);
    check("vframe_no_lock", 32'(locked), 32'd0);
    check("f6_frame_cnt", 32'(frame_cnt), 32'd6);

    // Frame 7: reset part-way through an active line.
    for (int l = 1; l < int'(V_FIRST) + 3; l++) send_line(l, H_TOTAL, H_SYNC, 1'b1, H_TOTAL);
    send_line(int'(V_FIRST) + 3, H_TOTAL, H_SYNC, 1'b1, H_FIRST + 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_valid", 32'(pxl_valid), 32'd0);
    check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_errors", 32'({err_hsync, err_hline, err_vframe, locked}), 32'd0);
    check("midrst_sb_empty", sb.size(), 32'd0);
    for (int l = int'(V_FIRST) + 4; l < int'(V_TOTAL); l++)
      send_line(l, H_TOTAL, H_SYNC, 1'b0, H_TOTAL);
    done_base = done_cnt;
    send_frame(V_TOTAL);
    check("f8_frame_cnt", 32'(frame_cnt), 32'd1);
    check("f8_done", done_cnt - done_base, 32'd1);
    check("f8_errors", 32'({err_hsync, err_hline, err_vframe}), 32'd0);

`ifdef SYN_VGA_RX_CRC_EN
    begin
      logic [15:0] model;
      model = 16'hFFFF;
      for (int i = 0; i < int'(H_ACTIVE * V_ACTIVE); i++) model = crc_word(model, 12'hFFF);
      const_rgb = 1'b1;
      send_frame(V_TOTAL);
      check("crc_frame1", 32'(frame_crc), 32'(model));
      send_frame(V_TOTAL);
      check("crc_frame2", 32'(frame_crc), 32'(model));
    end
`endif

    repeat (4) @(negedge clk);
    check("final_sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
